reg_bank_sb: RTL

- Register bank on the read side of the write-register selection path: 32 x 32-bit general registers, two combinational read ports, one synchronous write port.
- The write address comes from the RegDst-selected destination field. Read addresses come from instruction[25:21] (rs) and instruction[20:16] (rt).
- An integrated scoreboard tracks registers with an in-flight multi-cycle producer (loads) and raises stall when a read would return stale data.
- Sits between decode and execute; the control unit consumes stall.

---
 rtl/mips_pkg.sv | 9 +
 rtl/reg_bank_sb_if.sv | 16 +
 rtl/reg_scoreboard.sv | 30 +++
 rtl/reg_bank_sb.sv | 29 ++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared widths and types for the register bank slice
package mips_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS = 2 ** ADDR_W;
  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;
  localparam reg_addr_t REG_ZERO = reg_addr_t'(0);
endpackage

// File: rtl/reg_bank_sb_if.sv
// reg_bank_sb_if: read, write, issue and scoreboard signals of the register bank
interface reg_bank_sb_if;
  import mips_pkg::*;
  reg_addr_t rd_addr_a, rd_addr_b, wr_addr, issue_addr;
  logic rd_en_a, rd_en_b, wr_en, issue_en, stall;
  word_t rd_data_a, rd_data_b, wr_data;
  logic [NREGS-1:0] pending;
  modport master (
    output rd_addr_a, rd_en_a, rd_addr_b, rd_en_b, wr_en, wr_addr, wr_data, issue_en, issue_addr,
    input rd_data_a, rd_data_b, stall, pending
  );
  modport slave (
    input rd_addr_a, rd_en_a, rd_addr_b, rd_en_b, wr_en, wr_addr, wr_data, issue_en, issue_addr,
    output rd_data_a, rd_data_b, stall, pending
  );
endinterface

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: pending bits for in-flight producers and the read stall equation
module reg_scoreboard import mips_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  reg_addr_t        wr_addr,
  input  logic             issue_en,
  input  reg_addr_t        issue_addr,
  input  logic             rd_en_a,
  input  reg_addr_t        rd_addr_a,
  input  logic             rd_en_b,
  input  reg_addr_t        rd_addr_b,
  output logic [NREGS-1:0] pending,
  output logic             stall
);
  logic [NREGS-1:0] set_v, clr_v;
  logic hit_a, hit_b;
  always_comb begin
    set_v = issue_en ? NREGS'(1) << issue_addr : '0;
    clr_v = wr_en ? NREGS'(1) << wr_addr : '0;
    // a same-cycle retiring write is forwarded, so it cancels the hit
    hit_a = rd_en_a && pending[rd_addr_a] && !(wr_en && wr_addr == rd_addr_a);
    hit_b = rd_en_b && pending[rd_addr_b] && !(wr_en && wr_addr == rd_addr_b);
    stall = hit_a || hit_b;
  end
  // set after clear: a newer producer supersedes the retiring one
  always_ff @(posedge clk or posedge rst)
    if (rst) pending <= '0;
    else pending <= ((pending & ~clr_v) | set_v) & ~NREGS'(1);
endmodule

// File: rtl/reg_bank_sb.sv
// reg_bank_sb: 32x32 register bank with write-through bypass and load scoreboard
module reg_bank_sb import mips_pkg::*; (
  input logic clk,
  input logic rst,
  reg_bank_sb_if.slave bus
);
  word_t regs [NREGS];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    else if (bus.wr_en && bus.wr_addr != REG_ZERO) regs[bus.wr_addr] <= bus.wr_data;
  assign bus.rd_data_a = (bus.rd_addr_a == REG_ZERO) ? '0 :
                         (bus.wr_en && bus.wr_addr == bus.rd_addr_a) ? bus.wr_data : regs[bus.rd_addr_a];
  assign bus.rd_data_b = (bus.rd_addr_b == REG_ZERO) ? '0 :
                         (bus.wr_en && bus.wr_addr == bus.rd_addr_b) ? bus.wr_data : regs[bus.rd_addr_b];
  reg_scoreboard u_sb (
    .clk(clk),
    .rst(rst),
    .wr_en(bus.wr_en),
    .wr_addr(bus.wr_addr),
    .issue_en(bus.issue_en),
    .issue_addr(bus.issue_addr),
    .rd_en_a(bus.rd_en_a),
    .rd_addr_a(bus.rd_addr_a),
    .rd_en_b(bus.rd_en_b),
    .rd_addr_b(bus.rd_addr_b),
    .pending(bus.pending),
    .stall(bus.stall)
  );
endmodule
